// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA host link I/O blocks (parallel_to_serial, serial_to_parallel).
package rsa_io_pkg;

    // FSM state encoding, common to both directions of the link
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND    = 3'd3;
    localparam logic [STATE_W-1:0] ST_CSUM    = 3'd4;
    localparam logic [STATE_W-1:0] ST_FIN     = 3'd5;

    // Bytes in one standard 32-bit RAM word
    localparam int unsigned BYTES_PER_WORD = 4;

    // Ceiling log2; clog2(1) == 0
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Holds one RAM word and presents it MSB byte first; tracks which byte is on the bus.
module word_byte_shifter
    import rsa_io_pkg::*;
#(
    parameter int unsigned DBITS = 8 * BYTES_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DBITS-1:0] din,
    input  logic             shift,
    output logic [7:0]       cur_byte,
    output logic             last_c
);

    localparam int unsigned BPW   = DBITS / 8;
    localparam int unsigned CNT_W = clog2(BPW) + 1;

    logic [DBITS-1:0] shreg;
    logic [CNT_W-1:0] byte_cnt;

    // Load has priority so a new word can replace the one whose last byte just left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shreg    <= din;
            byte_cnt <= '0;
        end else if (shift) begin
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    assign cur_byte = shreg[DBITS-1 -: 8];
    assign last_c   = (byte_cnt == CNT_W'(BPW - 1));

endmodule

// File: rtl/parallel_to_serial.sv
// Return path of the RSA host link: reads WORDS result words from RAM and streams them
// MSB byte first on a valid/ready byte interface towards uart_tx.
// Optional feature: define PTS_CHECKSUM_EN to append an XOR checksum byte to each frame.
module parallel_to_serial
    import rsa_io_pkg::*;
#(
    parameter int unsigned DBITS    = 8 * BYTES_PER_WORD,
    parameter int unsigned ABITS    = 8,
    parameter int unsigned WORDS    = 4,
    parameter int unsigned RES_ADDR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [ABITS-1:0] rd_addr,
    output logic             rd_en,
    input  logic [DBITS-1:0] rd_data,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned WCW = clog2(WORDS) + 1;

    logic [STATE_W-1:0] state, state_nx;
    logic [WCW-1:0]     word_cnt, word_cnt_nx;
    logic [ABITS-1:0]   rd_addr_nx;
    logic               rd_en_nx;
    logic               tx_valid_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               xfer_c;
    logic               load_c;
    logic               shift_c;
    logic               last_c;
    logic [DBITS-1:0]   load_data_c;
`ifdef PTS_CHECKSUM_EN
    logic [7:0]         csum, csum_nx;
`endif

    assign xfer_c = tx_valid & tx_ready;

    // Byte staging for the word in flight; also carries the checksum byte when enabled
    word_byte_shifter #(
        .DBITS (DBITS)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .din      (load_data_c),
        .shift    (shift_c),
        .cur_byte (tx_byte),
        .last_c   (last_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        word_cnt_nx = word_cnt;
        rd_addr_nx  = rd_addr;
        rd_en_nx    = 1'b0;
        tx_valid_nx = tx_valid;
        busy_nx     = busy;
        done_nx     = 1'b0;
        load_c      = 1'b0;
        shift_c     = 1'b0;
        load_data_c = rd_data;
`ifdef PTS_CHECKSUM_EN
        csum_nx     = csum;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_nx     = 1'b1;
                    word_cnt_nx = '0;
                    rd_addr_nx  = ABITS'(RES_ADDR);
                    rd_en_nx    = 1'b1;
`ifdef PTS_CHECKSUM_EN
                    csum_nx     = '0;
`endif
                    state_nx    = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                state_nx = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                load_c      = 1'b1;
                tx_valid_nx = 1'b1;
                state_nx    = ST_SEND;
            end
            ST_SEND: begin
                if (xfer_c) begin
                    shift_c = 1'b1;
`ifdef PTS_CHECKSUM_EN
                    csum_nx = csum ^ tx_byte;
`endif
                    if (last_c) begin
                        tx_valid_nx = 1'b0;
                        if (word_cnt == WCW'(WORDS - 1)) begin
`ifdef PTS_CHECKSUM_EN
                            load_c      = 1'b1;
                            load_data_c = DBITS'(csum_nx) << (DBITS - 8);
                            tx_valid_nx = 1'b1;
                            state_nx    = ST_CSUM;
`else
                            done_nx  = 1'b1;
                            state_nx = ST_FIN;
`endif
                        end else begin
                            word_cnt_nx = word_cnt + WCW'(1);
                            rd_addr_nx  = rd_addr + ABITS'(1);
                            rd_en_nx    = 1'b1;
                            state_nx    = ST_RD_REQ;
                        end
                    end
                end
            end
            ST_CSUM: begin
`ifdef PTS_CHECKSUM_EN
                if (xfer_c) begin
                    tx_valid_nx = 1'b0;
                    done_nx     = 1'b1;
                    state_nx    = ST_FIN;
                end
`else
                // Unreachable without the checksum; recover to idle
                tx_valid_nx = 1'b0;
                busy_nx     = 1'b0;
                state_nx    = ST_IDLE;
`endif
            end
            ST_FIN: begin
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                tx_valid_nx = 1'b0;
                busy_nx     = 1'b0;
                state_nx    = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            word_cnt <= word_cnt_nx;
            rd_addr  <= rd_addr_nx;
            rd_en    <= rd_en_nx;
            tx_valid <= tx_valid_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

`ifdef PTS_CHECKSUM_EN
    // Running XOR of the data bytes of the current frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else begin
            csum <= csum_nx;
        end
    end
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: a WORDS=4 and a WORDS=1 instance, each with a small RAM model.
module tb_parallel_to_serial;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic tx_ready;

    logic        start4, start1;
    logic [7:0]  rd_addr4, rd_addr1;
    logic        rd_en4, rd_en1;
    logic [31:0] rd_data4, rd_data1;
    logic [7:0]  tx_byte4, tx_byte1;
    logic        tx_valid4, tx_valid1;
    logic        busy4, busy1;
    logic        done4, done1;

    logic [31:0] ram4 [256];
    logic [31:0] ram1 [256];

    logic [7:0]  rd_addr_v;
    logic        rd_en_v, tx_valid_v, busy_v, done_v;
    logic [7:0]  tx_byte_v;

    int total = 0;
    int bad   = 0;

    logic [7:0] byte_q [$];
    int         edge_q [$];
    logic [7:0] addr_q [$];
    logic [7:0] exp_b  [$];
    logic [7:0] exp_a  [$];
    int first_valid, done_cyc, done_count;
    logic busy_after_done, timed_out;

    always #5 clk = ~clk;

    assign start4     = start & ~sel;
    assign start1     = start & sel;
    assign rd_addr_v  = sel ? rd_addr1  : rd_addr4;
    assign rd_en_v    = sel ? rd_en1    : rd_en4;
    assign tx_valid_v = sel ? tx_valid1 : tx_valid4;
    assign tx_byte_v  = sel ? tx_byte1  : tx_byte4;
    assign busy_v     = sel ? busy1     : busy4;
    assign done_v     = sel ? done1     : done4;

    parallel_to_serial #(.DBITS(32), .ABITS(8), .WORDS(4), .RES_ADDR(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .rd_addr(rd_addr4), .rd_en(rd_en4),
        .rd_data(rd_data4), .tx_byte(tx_byte4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
        .busy(busy4), .done(done4)
    );

    parallel_to_serial #(.DBITS(32), .ABITS(8), .WORDS(1), .RES_ADDR(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_en(rd_en1),
        .rd_data(rd_data1), .tx_byte(tx_byte1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .done(done1)
    );

    // RAM models with one cycle read latency
    always @(posedge clk) if (rd_en4) rd_data4 <= ram4[rd_addr4];
    always @(posedge clk) if (rd_en1) rd_data1 <= ram1[rd_addr1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run one transaction on the selected instance, recording bytes, transfer edges and read addresses
    task automatic run_frame(input logic s, input bit rnd, input bit extra_starts,
                             input bit fin_start, input int stop_after);
        int cyc;
        logic prev_stall;
        logic [7:0] prev_byte;
        byte_q.delete(); edge_q.delete(); addr_q.delete();
        first_valid = -1; done_cyc = -1; done_count = 0;
        busy_after_done = 1'b1; timed_out = 1'b0;
        prev_stall = 1'b0; prev_byte = 8'h00;
        sel = s;
        tx_ready = 1'b1;
        start = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (extra_starts && (cyc == 2 || cyc == 6)) start = 1'b1;
            if (rd_en_v) addr_q.push_back(rd_addr_v);
            if (tx_valid_v && first_valid < 0) first_valid = cyc;
            if (prev_stall) begin
                check_eq("hold_valid", 32'(tx_valid_v), 32'd1);
                check_eq("hold_byte", 32'(tx_byte_v), 32'(prev_byte));
            end
            if (done_v) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
                if (fin_start) start = 1'b1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after_done = busy_v;
                break;
            end
            if (stop_after > 0 && byte_q.size() == stop_after) break;
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid_v && tx_ready) begin
                byte_q.push_back(tx_byte_v);
                edge_q.push_back(cyc + 1);
            end
            prev_stall = tx_valid_v && !tx_ready;
            prev_byte  = tx_byte_v;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        check_eq("timeout", 32'(timed_out), 32'd0);
    endtask

    // Compare captured frame against exp_b/exp_a; optionally check cycle-exact spacing
    task automatic check_frame(input string tag, input bit timing, input int ndata);
        int n;
        check_eq({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_b.size()));
        n = (byte_q.size() < exp_b.size()) ? byte_q.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_b[i]));
        end
        check_eq({tag, "_naddr"}, 32'(addr_q.size()), 32'(exp_a.size()));
        n = (addr_q.size() < exp_a.size()) ? addr_q.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_a[i]));
        end
        check_eq({tag, "_done_once"}, 32'(done_count), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy_after_done), 32'd0);
        if (timing && edge_q.size() == exp_b.size()) begin
            check_eq({tag, "_first_valid"}, 32'(first_valid), 32'd3);
            for (int i = 1; i < edge_q.size(); i++) begin
                check_eq($sformatf("%s_gap%0d", tag, i), 32'(edge_q[i] - edge_q[i-1]),
                         (i < ndata && (i % 4) == 0) ? 32'd3 : 32'd1);
            end
            check_eq({tag, "_done_time"}, 32'(done_cyc), 32'(edge_q[edge_q.size()-1]));
        end
    endtask

    task automatic load_exp4();
        exp_b.delete(); exp_a.delete();
        for (int i = 0; i < 16; i++) exp_b.push_back(8'(i * 8'h11));
`ifdef PTS_CHECKSUM_EN
        exp_b.push_back(8'h00);
`endif
        for (int i = 4; i < 8; i++) exp_a.push_back(8'(i));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ram4[i] = 32'hA5A5_0000 | 32'(i);
            ram1[i] = 32'h5A5A_0000 | 32'(i);
        end
        ram1[4] = 32'hDEADBEEF;
        ram4[4] = 32'h00112233; ram4[5] = 32'h44556677;
        ram4[6] = 32'h8899AABB; ram4[7] = 32'hCCDDEEFF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx_valid", 32'({tx_valid4, tx_valid1}), 32'd0);
        check_eq("rst_busy",     32'({busy4, busy1}), 32'd0);
        check_eq("rst_done",     32'({done4, done1}), 32'd0);
        check_eq("rst_rd_en",    32'({rd_en4, rd_en1}), 32'd0);
        check_eq("rst_rd_addr",  32'({rd_addr4, rd_addr1}), 32'd0);
        check_eq("rst_tx_byte",  32'({tx_byte4, tx_byte1}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single word, start in the FIN cycle must be ignored
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef PTS_CHECKSUM_EN
        exp_b.push_back(8'h22);
`endif
        exp_a = '{8'h04};
        run_frame(1'b1, 1'b0, 1'b0, 1'b1, 0);
        check_frame("w1", 1'b1, 4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("fin_start_rd_en", 32'(rd_en1), 32'd0);
            check_eq("fin_start_busy", 32'(busy1), 32'd0);
        end

        // Four words at full rate
        load_exp4();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_frame("w4", 1'b1, 16);

        // Random backpressure
        for (int r = 0; r < 3; r++) begin
            load_exp4();
            run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);
            check_frame($sformatf("bp%0d", r), 1'b0, 16);
        end

        // Start pulses while busy, then a fresh frame after done
        load_exp4();
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_frame("restart", 1'b1, 16);
        load_exp4();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_frame("after_done", 1'b1, 16);

        // Asynchronous reset after two bytes of the first word
        load_exp4();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 2);
        check_eq("pre_rst_valid", 32'(tx_valid4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(tx_valid4), 32'd0);
        check_eq("mid_rst_busy", 32'(busy4), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        load_exp4();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_frame("post_rst", 1'b1, 16);

        // Checksum pattern on the single-word instance
        ram1[4] = 32'h01020304;
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
`ifdef PTS_CHECKSUM_EN
        exp_b.push_back(8'h04);
`endif
        exp_a = '{8'h04};
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_frame("csum", 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
